seq_alu_pipe: RTL and testbench

- Parametrised, handshaked ALU for the sequential RISC-V datapath.
- Generalises the team's fixed 64-bit combinational add/sub/and/or block to WIDTH bits.
- Adds xor, signed/unsigned compare, an iterative shift-add multiplier, registered status flags and valid/ready flow control.
- Sits between register-read and writeback; the execute FSM issues one operation at a time.

---
 rtl/seq_alu_pipe.sv | 179 +++++++++++++++++
 tb/tb_seq_alu_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu_pipe                                                 |
// | Description : Handshaked WIDTH-bit ALU for the sequential RISC-V datapath. |
// |               Supports add/sub/and/or/xor/slt/sltu, an optional iterative  |
// |               shift-add multiplier, and registered zero/carry/overflow/err.|
// |               One operation in flight at a time (IDLE -> [MUL] -> DONE).   |
// | Options     : SEQ_ALU_MUL_EN - build the multiplier; otherwise op 7 is     |
// |               reported as illegal with 1-cycle latency.                    |
// | Ports       : clk, reset (sync, active-high)                               |
// |               in_valid/in_ready, op[3:0], a, b    - request side           |
// |               out_valid/out_ready, result, zero, carry, overflow, err      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_alu_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd1;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_hs;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_step;
    logic             w_is_mul;

    assign w_is_mul   = (op == 4'd7);
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = (r_state == S_DONE);
    assign w_hs      = in_valid && (r_state == S_IDLE);

    // Single adder serves both ADD and SUB: SUB is a + ~b + 1.
    assign w_is_sub = (op == 4'd1);
    assign w_b_eff  = w_is_sub ? ~b : b;
    assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:    w_res = a & b;
            4'd3:    w_res = a | b;
            4'd4:    w_res = a ^ b;
            4'd5:    w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6:    w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // Op 7 lands here only when the multiplier is not built.
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                    w_state_nxt = w_is_mul ? S_MUL : S_DONE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_MUL: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
`ifdef SEQ_ALU_MUL_EN
            if (w_hs && w_is_mul) begin
                // The first add step is folded into the load so that WIDTH
                // steps fit in WIDTH-1 MUL cycles, giving WIDTH-cycle latency.
                r_acc    <= b[0] ? a : '0;
                r_mcand  <= a << 1;
                r_mplier <= b >> 1;
                r_cnt    <= CNT_W'(1);
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (r_cnt == c_last) begin
                    result   <= w_acc_step;
                    zero     <= (w_acc_step == '0);
                    carry    <= 1'b0;
                    overflow <= 1'b0;
                    err      <= 1'b0;
                end
            end else
`endif
            if (w_hs) begin
                result   <= w_res;
                zero     <= (w_res == '0);
                carry    <= w_carry;
                overflow <= w_ovf;
                err      <= w_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_alu_pipe                                              |
// | Description : Self-checking bench for seq_alu_pipe. A 64-bit and an 8-bit  |
// |               instance share op/a/b/out_ready; a behavioural model checks  |
// |               handshake, latency, result and flags every cycle.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_alu_pipe;

`ifdef SEQ_ALU_MUL_EN
    localparam bit c_mul_en = 1'b1;
`else
    localparam bit c_mul_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        out_ready;
    logic [1:0]  iv, ir, ov, zf, cf, vf, ef;
    logic [63:0] res0;
    logic [7:0]  res1;

    always #5 clk = ~clk;

    seq_alu_pipe #(.WIDTH(64)) u_d64 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(op),
        .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .result(res0),
        .zero(zf[0]), .carry(cf[0]), .overflow(vf[0]), .err(ef[0])
    );

    seq_alu_pipe #(.WIDTH(8)) u_d8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(op),
        .a(a[7:0]), .b(b[7:0]), .out_valid(ov[1]), .out_ready(out_ready), .result(res1),
        .zero(zf[1]), .carry(cf[1]), .overflow(vf[1]), .err(ef[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected {err, overflow, carry, zero, result} for a w-bit ALU.
    function automatic logic [67:0] model(input int w, input logic [3:0] o,
                                          input logic [63:0] x_in, input logic [63:0] y_in);
        logic [63:0] m, x, y, r;
        logic [64:0] s;
        logic        c, v, e;
        m = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x = x_in & m;
        y = y_in & m;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0; s = '0;
        case (o)
            4'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[63:0] & m;
                c = s[w];
                v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
            end
            4'd1: begin
                s = {1'b0, x} + {1'b0, (~y) & m} + 65'd1;
                r = s[63:0] & m;
                c = s[w];
                v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = (x[w-1] != y[w-1]) ? {63'd0, x[w-1]} : {63'd0, (x < y)};
            4'd6: r = {63'd0, (x < y)};
            4'd7: begin
                if (c_mul_en) r = (x * y) & m;
                else          e = 1'b1;
            end
            default: e = 1'b1;
        endcase
        return {e, v, c, (r == 64'd0), r};
    endfunction

    // Model state per instance (0: 64-bit, 1: 8-bit).
    bit          armed = 1'b0;
    int          k = 0;
    bit          busy [2];
    bit          after_rst [2];
    int          hs [2];
    int          lat [2];
    logic [67:0] expv [2];
    logic [67:0] last [2];

    always @(negedge clk) begin
        if (armed) begin
            k++;
            for (int u = 0; u < 2; u++) begin
                logic [67:0] act;
                bit          erdy, evld;
                int          w;
                w    = (u == 0) ? 64 : 8;
                act  = {ef[u], vf[u], cf[u], zf[u], ((u == 0) ? res0 : {56'd0, res1})};
                erdy = !busy[u] && !reset;
                evld = busy[u] && ((k - hs[u]) >= lat[u]);
                chk($sformatf("in_ready[%0d]", u), {67'd0, ir[u]}, {67'd0, erdy});
                chk($sformatf("out_valid[%0d]", u), {67'd0, ov[u]}, {67'd0, evld});
                if (evld) begin
                    chk($sformatf("result_flags[%0d]", u), act, expv[u]);
                    last[u] = act;
                end else if (after_rst[u]) begin
                    chk($sformatf("reset_outputs[%0d]", u), act, 68'd0);
                end
                if (reset) begin
                    busy[u]      = 1'b0;
                    after_rst[u] = 1'b1;
                end else if (evld && out_ready) begin
                    busy[u] = 1'b0;
                end else if (iv[u] && erdy) begin
                    expv[u]      = model(w, op, a, b);
                    lat[u]       = (op == 4'd7 && c_mul_en) ? w : 1;
                    hs[u]        = k;
                    busy[u]      = 1'b1;
                    after_rst[u] = 1'b0;
                end
            end
        end
    end

    bit rnd_bp = 1'b0;

    // Starts and ends #1 after a rising edge.
    task automatic issue(input int u, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        bit got;
        got = 1'b0;
        op = o; a = x; b = y; iv[u] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ir[u]) begin got = 1'b1; break; end
        end
        if (!got) chk("handshake_timeout", 68'd0, 68'd1);
        @(posedge clk); #1;
        iv[u] = 1'b0;
        // Scramble operands: the DUT must not sample them after the handshake.
        op = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int u);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!busy[u]) begin done = 1'b1; break; end
            if (rnd_bp) out_ready = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        if (!done) chk("done_timeout", 68'd0, 68'd1);
        out_ready = 1'b1;
    endtask

    task automatic run(input int u, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        issue(u, o, x, y);
        wait_done(u);
    endtask

    function automatic logic [63:0] rand_opnd();
        case ($urandom % 6)
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0080;
            3:       return 64'h7FFF_FFFF_FFFF_FF7F;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        reset = 1'b1; iv = 2'b00; op = 4'd0; a = '0; b = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        armed = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // 64-bit add/sub corner cases.
        run(0, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add64_ovf", last[0], {4'b0100, 64'h8000_0000_0000_0000});
        run(0, 4'd1, 64'd5, 64'd5);
        chk("sub64_zero", last[0], {4'b0011, 64'd0});
        run(0, 4'd1, 64'd0, 64'd1);
        chk("sub64_borrow", last[0], {4'b0000, 64'hFFFF_FFFF_FFFF_FFFF});

        // 8-bit compares and illegal op.
        run(1, 4'd5, 64'hFF, 64'h01);
        chk("slt8", last[1], {4'b0000, 64'd1});
        run(1, 4'd6, 64'hFF, 64'h01);
        chk("sltu8", last[1], {4'b0001, 64'd0});
        run(1, 4'd12, 64'h12, 64'h34);
        chk("illegal8", last[1], {4'b1001, 64'd0});

        // Multiplier (or illegal op 7 when not built).
        run(1, 4'd7, 64'd13, 64'd11);
        chk("mul8_13x11", last[1], c_mul_en ? {4'b0000, 64'h8F} : {4'b1001, 64'd0});
        run(1, 4'd7, 64'hFF, 64'hFF);
        chk("mul8_ffxff", last[1], c_mul_en ? {4'b0000, 64'h01} : {4'b1001, 64'd0});

        // Backpressure: result held, new request ignored, then released.
        out_ready = 1'b0;
        issue(1, 4'd4, 64'h5A, 64'h0F);
        iv[1] = 1'b1; op = 4'd0; a = 64'h1; b = 64'h1;
        repeat (6) @(posedge clk);
        #1 iv[1] = 1'b0;
        out_ready = 1'b1;
        wait_done(1);
        chk("xor8_backpressure", last[1], {4'b0000, 64'h55});
        run(1, 4'd3, 64'h50, 64'h0A);
        chk("or8_after_bp", last[1], {4'b0000, 64'h5A});

        // Reset in the middle of a multiply.
        issue(1, 4'd7, 64'd13, 64'd11);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        run(1, 4'd0, 64'd2, 64'd3);
        chk("add8_after_reset", last[1], {4'b0000, 64'd5});

        // Randomised operations with random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 120; i++) begin
            int          u;
            logic [3:0]  o;
            u = $urandom % 2;
            o = (($urandom % 5) == 0) ? 4'd7 : 4'($urandom % 16);
            run(u, o, rand_opnd(), rand_opnd());
        end
        rnd_bp = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
